os_bank_loader: RTL

Upstream fill stage for the output-stationary bank-to-FIFO sequencer. Accepts a valid/ready word stream, writes it into the weight bank and then the activation bank, and raises `mem_load_complete_o` for the sequencer's `mem_load_complete_i`.
- Weight bank: 72 words, read in one pass.
- Activation bank: 144 words, read as two 72-word halves.

One load covers exactly both banks. A new load requires an explicit `start_i`.

---
 rtl/os_bank_loader.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/os_bank_loader.sv
// os_bank_loader: fills the weight bank, then the activation bank, from one
// valid/ready word stream. It raises a level "load complete" for the
// downstream bank-to-FIFO sequencer. A new load needs an explicit start.
module os_bank_loader #(
   parameter int bw      = 4,
   parameter int row     = 8,
   parameter int w_depth = 72,
   parameter int x_depth = 144
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start_i,
   input  logic                in_valid_i,
   input  logic [row*bw-1:0]   in_data_i,
   output logic                in_ready_o,
   output logic                w_bank_write_en_n_o,
   output logic [6:0]          w_bank_write_addr_o,
   output logic                x_bank_write_en_n_o,
   output logic [7:0]          x_bank_write_addr_o,
   output logic [row*bw-1:0]   bank_write_data_o,
   output logic                mem_load_complete_o
);

   localparam logic [6:0] W_LAST = 7'(w_depth - 1);
   localparam logic [7:0] X_LAST = 8'(x_depth - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD_W = 3'd1,
      LOAD_X = 3'd2,
      FLUSH  = 3'd3,
      DONE   = 3'd4
   } state_t;

   state_t            state_r;
   state_t            state_s;
   logic [6:0]        wcnt_r;
   logic [7:0]        xcnt_r;
   logic              accept_s;
   logic              w_acc_s;
   logic              x_acc_s;
   logic              restart_s;
   logic              w_en_n_r;
   logic [6:0]        w_addr_r;
   logic              x_en_n_r;
   logic [7:0]        x_addr_r;
   logic [row*bw-1:0] data_r;

   // Handshake and write qualifiers decoded from the state register only.
   always_comb begin
      in_ready_o          = 1'b0;
      mem_load_complete_o = 1'b0;
      restart_s           = 1'b0;
      if ((state_r == LOAD_W) || (state_r == LOAD_X)) begin
         in_ready_o = 1'b1;
      end else begin
         in_ready_o = 1'b0;
      end
      if (state_r == DONE) begin
         mem_load_complete_o = 1'b1;
      end else begin
         mem_load_complete_o = 1'b0;
      end
      if (((state_r == IDLE) || (state_r == DONE)) && start_i) begin
         restart_s = 1'b1;
      end else begin
         restart_s = 1'b0;
      end
      accept_s = in_valid_i & in_ready_o;
      w_acc_s  = accept_s & (state_r == LOAD_W);
      x_acc_s  = accept_s & (state_r == LOAD_X);
   end

   // Next-state decode; terminal counter compares force the bank switch.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (start_i) state_s = LOAD_W;
            else         state_s = IDLE;
         end
         LOAD_W: begin
            if (w_acc_s && (wcnt_r == W_LAST)) state_s = LOAD_X;
            else                               state_s = LOAD_W;
         end
         LOAD_X: begin
            if (x_acc_s && (xcnt_r == X_LAST)) state_s = FLUSH;
            else                               state_s = LOAD_X;
         end
         FLUSH: begin
            state_s = DONE;
         end
         DONE: begin
            if (start_i) state_s = LOAD_W;
            else         state_s = DONE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_r <= IDLE;
      else       state_r <= state_s;
   end

   // Word counters: cleared on start, advanced per accepted word of each bank.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wcnt_r <= 7'd0;
         xcnt_r <= 8'd0;
      end else if (restart_s) begin
         wcnt_r <= 7'd0;
         xcnt_r <= 8'd0;
      end else if (w_acc_s) begin
         wcnt_r <= wcnt_r + 7'd1;
      end else if (x_acc_s) begin
         xcnt_r <= xcnt_r + 8'd1;
      end
   end

   // Registered bank write port: one-cycle strobes, held address and data.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         w_en_n_r <= 1'b1;
         w_addr_r <= 7'd0;
         x_en_n_r <= 1'b1;
         x_addr_r <= 8'd0;
         data_r   <= '0;
      end else begin
         w_en_n_r <= ~w_acc_s;
         x_en_n_r <= ~x_acc_s;
         if (w_acc_s) w_addr_r <= wcnt_r;
         if (x_acc_s) x_addr_r <= xcnt_r;
         if (accept_s) data_r <= in_data_i;
      end
   end

   assign w_bank_write_en_n_o = w_en_n_r;
   assign w_bank_write_addr_o = w_addr_r;
   assign x_bank_write_en_n_o = x_en_n_r;
   assign x_bank_write_addr_o = x_addr_r;
   assign bank_write_data_o   = data_r;

endmodule
